activation_feeder: RTL and testbench
====================================

// Module: activation_feeder
// PURPOSE
//  Input-side stage in front of the systolic array: buffers activation row vectors from the
//  host/memory side, then feeds them into the array's west edge with the diagonal skew the
//  array needs (lane r delayed r cycles relative to lane 0). Feeding is gated by the
//  scheduler's enable_mult/general_enable. feed_done is raised once the last vector has left
//  every lane.
// PARAMETERS
//  MATRIX_SIZE  2   array dimension N; number of lanes/rows fed
//  DATA_SIZE    32  bits per activation element
//  FIFO_DEPTH   4   input vector FIFO entries; power of 2, >=2
// PORTS
//  clk             in   1                 rising-edge clock
//  reset_n         in   1                 asynchronous, active-low reset
//  general_enable  in   1                 global stall; 0 freezes all state
//  in_valid        in   1                 input vector valid
//  in_ready        out  1                 feeder can accept a vector this cycle
//  in_data         in   MATRIX_SIZE*DATA_SIZE  vector; lane r = bits [r*DATA_SIZE +: DATA_SIZE]
//  in_last         in   1                 marks final vector of the matrix
//  enable_mult     in   MATRIX_SIZE       from scheduler; bit 0 gates popping
//  sched_done      in   1                 scheduler done; releases DONE state
//  a_out           out  MATRIX_SIZE*DATA_SIZE  skewed activations to array west edge
//  a_valid         out  MATRIX_SIZE       per-lane valid, aligned with a_out
//  feed_done       out  1                 all vectors of the matrix have been fed
// BEHAVIOUR
//  Reset (reset_n=0, async): FIFO empty, state IDLE, all skew registers 0, a_out=0,
//   a_valid=0, feed_done=0. Reset mid-operation discards the FIFO and all in-flight lanes.
//  Stall: general_enable=0 -> no push, no pop, no skew shift, no state change; in_ready=0.
//  Input handshake: push when in_valid && in_ready. in_ready = general_enable && !full &&
//   state in {IDLE,FEED}. Full FIFO refuses pushes even on a pop cycle. in_data/in_last
//   stored together (DATA+1 bits/entry). Pointers wrap modulo FIFO_DEPTH; count N+1 bits wide.
//  Pop: pop = general_enable && !empty && enable_mult[0] && state in {IDLE,FEED}.
//  Skew: lane r has r+1 register stages. Popped vector lane r appears on a_out lane r with
//   a_valid[r]=1 exactly r+1 cycles after the pop edge. Non-pop cycles inject bubbles:
//   valid 0, data 0 (a_out lane is 0 whenever a_valid bit is 0).
//  FSM:
//   IDLE  -> FEED  on first pop.
//   FEED  -> DRAIN on pop of an entry tagged last; stays FEED otherwise (empty FIFO = bubbles).
//   DRAIN: no pops, bubbles injected; counter runs MATRIX_SIZE cycles, then -> DONE
//          (last lane MATRIX_SIZE-1 has emitted its final element).
//   DONE:  feed_done=1 (registered); in_ready=0; -> IDLE when sched_done=1 (feed_done drops
//          next cycle). Pushes in DRAIN/DONE are held off until IDLE.
//  Simultaneous push+pop on a non-full FIFO: both occur, count unchanged.
//  in_last on a single vector with MATRIX_SIZE=1: FEED->DRAIN->DONE after 1 drain cycle.
// TESTING
//  1 N=2: push V0={1,2}, V1={3,4,last}, enable_mult=11 -> a_valid[0] cycles t+1,t+2 data 1,3;
//    lane1 at t+2,t+3 data 2,4; feed_done high at t+4.
//  2 enable_mult=00 with 4 pushes -> FIFO full, in_ready=0, 5th in_valid not accepted,
//    a_valid stays 00; raise enable_mult -> 4 vectors emerge in order.
//  3 general_enable=0 for 3 cycles mid-FEED -> a_out/a_valid/FIFO count frozen, resume intact.
//  4 reset_n pulsed low during DRAIN -> outputs 0, in_ready=1 next cycle, FIFO empty.
//  5 FIFO empty gap between V0 and V1 -> one bubble (a_valid bit 0, data 0) per lane
//    between them.
//  6 DONE held until sched_done=1 -> in_ready 0 meanwhile; IDLE and in_ready=1 after.

Source files
------------

// File: rtl/activation_feeder.sv
// Activation feeder: buffers row vectors in a small FIFO and drives them into the
// systolic array west edge with a per-lane diagonal skew (lane r delayed r cycles).
`timescale 1ns/1ps
module activation_feeder #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             general_enable,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0] in_data,
  input  logic                             in_last,
  input  logic [MATRIX_SIZE-1:0]           enable_mult,
  input  logic                             sched_done,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0] a_out,
  output logic [MATRIX_SIZE-1:0]           a_valid,
  output logic                             feed_done
);

  localparam int VEC_W   = MATRIX_SIZE * DATA_SIZE;
  localparam int ENTRY_W = VEC_W + 1;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int DRAIN_W = $clog2(MATRIX_SIZE) + 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t               state_reg, state_next;
  logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [DRAIN_W-1:0]   drain_cnt_reg, drain_cnt_next;
  logic                 feed_done_reg;
  logic                 full, empty, accept_state, push, pop;
  logic [ENTRY_W-1:0]   head;
  logic [VEC_W-1:0]     head_vec;
  logic                 head_last;
  logic                 unused_enable_bits;

  // Only bit 0 of enable_mult gates the feed; upper bits belong to other stages.
  assign unused_enable_bits = &{1'b0, enable_mult};

  assign full         = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty        = (count_reg == '0);
  assign accept_state = (state_reg == IDLE) || (state_reg == FEED);
  assign in_ready     = general_enable && !full && accept_state;
  assign push         = in_valid && in_ready;
  assign pop          = general_enable && !empty && enable_mult[0] && accept_state;

  // Head is read combinationally so a popped vector enters skew stage 0 on the pop edge.
  assign head      = fifo_mem[rd_ptr_reg];
  assign head_vec  = head[VEC_W-1:0];
  assign head_last = head[VEC_W];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {in_last, in_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    if (general_enable) begin
      case (state_reg)
        IDLE, FEED: begin
          if (pop) begin
            state_next     = head_last ? DRAIN : FEED;
            drain_cnt_next = '0;
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == DRAIN_W'(MATRIX_SIZE - 1)) state_next = DONE;
          else drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
        end
        DONE: begin
          if (sched_done) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      drain_cnt_reg <= '0;
      feed_done_reg <= 1'b0;
    end else if (general_enable) begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      feed_done_reg <= (state_next == DONE);
    end
  end

  assign feed_done = feed_done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < MATRIX_SIZE; gi++) begin : g_lane
      logic [DATA_SIZE-1:0] data_pipe [gi+1];
      logic [gi:0]          valid_pipe;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 0; s <= gi; s++) data_pipe[s] <= '0;
          valid_pipe <= '0;
        end else if (general_enable) begin
          data_pipe[0]  <= pop ? head_vec[gi*DATA_SIZE +: DATA_SIZE] : '0;
          valid_pipe[0] <= pop;
          for (int s = 1; s <= gi; s++) begin
            data_pipe[s]  <= data_pipe[s-1];
            valid_pipe[s] <= valid_pipe[s-1];
          end
        end
      end

      assign a_out[gi*DATA_SIZE +: DATA_SIZE] = data_pipe[gi];
      assign a_valid[gi]                      = valid_pipe[gi];
    end
  endgenerate

endmodule

// File: tb/tb_activation_feeder.sv
// Self-checking bench for activation_feeder: scoreboard of per-lane expected data plus
// cycle-exact checks of skew, bubbles, stall, reset and the DONE handshake.
`timescale 1ns/1ps
module tb_activation_feeder;
  localparam int N = 2;
  localparam int W = 32;

  logic           clk;
  logic           reset_n;
  logic           general_enable;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           in_last;
  logic [N-1:0]   enable_mult;
  logic           sched_done;
  logic [N*W-1:0] a_out;
  logic [N-1:0]   a_valid;
  logic           feed_done;

  activation_feeder #(.MATRIX_SIZE(N), .DATA_SIZE(W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .general_enable(general_enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .enable_mult(enable_mult), .sched_done(sched_done),
    .a_out(a_out), .a_valid(a_valid), .feed_done(feed_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  bit   mon_en = 1'b0;
  logic ge_q;

  typedef struct {
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         last;
    logic [W-1:0] e0;
    logic [W-1:0] e1;
  } vec_t;
  vec_t tbl[4];

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs are new only if the preceding edge was enabled; stalled repeats are skipped.
  always @(posedge clk) ge_q <= general_enable;

  always @(negedge clk) begin
    if (mon_en && reset_n === 1'b1 && ge_q === 1'b1) begin
      if (a_valid[0] === 1'b1) begin
        if (exp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL lane0_unexpected: got data %0h, expected no output", a_out[W-1:0]);
        end else check_eq("lane0_data", a_out[W-1:0], exp_q0.pop_front());
      end else check_eq("lane0_bubble", a_out[W-1:0], 0);
      if (a_valid[1] === 1'b1) begin
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL lane1_unexpected: got data %0h, expected no output", a_out[2*W-1:W]);
        end else check_eq("lane1_data", a_out[2*W-1:W], exp_q1.pop_front());
      end else check_eq("lane1_bubble", a_out[2*W-1:W], 0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic push_vec(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic last,
                          input logic [W-1:0] e0, input logic [W-1:0] e1);
    bit accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = {d1, d0};
    in_last  = last;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq("push_accepted", accepted, 1'b1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (feed_done) seen = 1'b1;
    end
    check_eq("feed_done_reached", seen, 1'b1);
  endtask

  task automatic finish_matrix();
    @(posedge clk); #1;
    sched_done = 1'b1;
    @(negedge clk);
    check_eq("done_before_release", feed_done, 1'b1);
    @(posedge clk); #1;
    sched_done = 1'b0;
    @(negedge clk);
    check_eq("done_dropped", feed_done, 1'b0);
    check_eq("ready_after_done", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{d0: 32'hA0, d1: 32'hA1, last: 1'b0, e0: 32'hA0, e1: 32'hA1};
    tbl[1] = '{d0: 32'hB0, d1: 32'hB1, last: 1'b0, e0: 32'hB0, e1: 32'hB1};
    tbl[2] = '{d0: 32'hC0, d1: 32'hC1, last: 1'b0, e0: 32'hC0, e1: 32'hC1};
    tbl[3] = '{d0: 32'hD0, d1: 32'hD1, last: 1'b1, e0: 32'hD0, e1: 32'hD1};

    reset_n = 1'b0; general_enable = 1'b1; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; enable_mult = '0; sched_done = 1'b0;
    @(negedge clk);
    check_eq("reset_a_valid", a_valid, 0);
    check_eq("reset_a_out", a_out, 0);
    check_eq("reset_feed_done", feed_done, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);
    check_eq("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Two-vector matrix: exact skew timing, then DONE held until sched_done.
    push_vec(32'd1, 32'd2, 1'b0, 32'd1, 32'd2);
    push_vec(32'd3, 32'd4, 1'b1, 32'd3, 32'd4);
    enable_mult = 2'b11;
    @(negedge clk);
    check_eq("t1_c0_valid", a_valid, 2'b00);
    step();
    check_eq("t1_c1_valid", a_valid, 2'b01);
    check_eq("t1_c1_lane0", a_out[W-1:0], 1);
    step();
    check_eq("t1_c2_valid", a_valid, 2'b11);
    check_eq("t1_c2_lane0", a_out[W-1:0], 3);
    check_eq("t1_c2_lane1", a_out[2*W-1:W], 2);
    step();
    check_eq("t1_c3_valid", a_valid, 2'b10);
    check_eq("t1_c3_lane1", a_out[2*W-1:W], 4);
    check_eq("t1_c3_done", feed_done, 1'b0);
    step();
    check_eq("t1_c4_done", feed_done, 1'b1);
    check_eq("t1_c4_valid", a_valid, 2'b00);
    check_eq("t1_c4_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t6_hold_done", feed_done, 1'b1);
      check_eq("t6_hold_ready", in_ready, 1'b0);
    end
    finish_matrix();
    check_eq("t1_drained", exp_q0.size() + exp_q1.size(), 0);

    // Table-driven fill with feeding blocked, refused fifth push, then release in order.
    enable_mult = 2'b00;
    for (int i = 0; i < 4; i++) push_vec(tbl[i].d0, tbl[i].d1, tbl[i].last, tbl[i].e0, tbl[i].e1);
    in_valid = 1'b1;
    in_data  = {32'hEE1, 32'hEE0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t2_full_ready", in_ready, 1'b0);
      check_eq("t2_no_output", a_valid, 2'b00);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    enable_mult = 2'b11;
    wait_done();
    finish_matrix();
    check_eq("t2_drained", exp_q0.size() + exp_q1.size(), 0);

    // Stall for three cycles mid-FEED with one vector still queued.
    enable_mult = 2'b00;
    push_vec(32'h10, 32'h11, 1'b0, 32'h10, 32'h11);
    push_vec(32'h20, 32'h21, 1'b0, 32'h20, 32'h21);
    push_vec(32'h30, 32'h31, 1'b1, 32'h30, 32'h31);
    enable_mult = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    general_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t3_stall_valid", a_valid, 2'b11);
      check_eq("t3_stall_lane0", a_out[W-1:0], 32'h20);
      check_eq("t3_stall_lane1", a_out[2*W-1:W], 32'h11);
      check_eq("t3_stall_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    general_enable = 1'b1;
    wait_done();
    finish_matrix();
    check_eq("t3_drained", exp_q0.size() + exp_q1.size(), 0);

    // Asynchronous reset during DRAIN with a vector still in the FIFO.
    enable_mult = 2'b00;
    push_vec(32'h40, 32'h41, 1'b1, 32'h40, 32'h41);
    push_vec(32'h50, 32'h51, 1'b0, 32'h50, 32'h51);
    enable_mult = 2'b11;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_eq("t4_rst_valid", a_valid, 0);
    check_eq("t4_rst_a_out", a_out, 0);
    check_eq("t4_rst_done", feed_done, 0);
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("t4_ready_after_reset", in_ready, 1'b1);
    check_eq("t4_valid_after_reset", a_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t4_fifo_empty", a_valid, 0);
    end
    enable_mult = 2'b00;
    @(posedge clk); #1;

    // Empty-FIFO gap between two vectors leaves one bubble per lane.
    enable_mult = 2'b11;
    in_valid = 1'b1; in_data = {32'h61, 32'h60}; in_last = 1'b0;
    @(negedge clk);
    check_eq("t5_v0_ready", in_ready, 1'b1);
    exp_q0.push_back(32'h60); exp_q1.push_back(32'h61);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = {32'h71, 32'h70}; in_last = 1'b1;
    @(negedge clk);
    check_eq("t5_p2_valid", a_valid, 2'b01);
    check_eq("t5_v1_ready", in_ready, 1'b1);
    exp_q0.push_back(32'h70); exp_q1.push_back(32'h71);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check_eq("t5_p3_valid", a_valid, 2'b10);
    check_eq("t5_p3_lane0_bubble", a_out[W-1:0], 0);
    step();
    check_eq("t5_p4_valid", a_valid, 2'b01);
    check_eq("t5_p4_lane1_bubble", a_out[2*W-1:W], 0);
    step();
    check_eq("t5_p5_valid", a_valid, 2'b10);
    step();
    check_eq("t5_p6_done", feed_done, 1'b1);
    finish_matrix();
    check_eq("t5_drained", exp_q0.size() + exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
